coeffs_bank_ctrl: RTL and testbench

- Multi-band, parametrised coefficient store for the equalizer FIR datapath.
- Host writes go into a staging bank.
- A swap request copies staging into the active (shadow) bank, either at the next sample-frame boundary or immediately.
- The active bank feeds every band's MAC tap by tap, selected by `current_count`.

---
 rtl/coeffs_bank_ctrl.sv | 144 ++++++++++++++
 tb/tb_coeffs_bank_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeffs_bank_ctrl.sv
// Double-buffered multi-band FIR coefficient store: host writes land in staging,
// a swap copies staging into the active bank. Optional readback port: COEFFS_READBACK_EN.
module coeffs_bank_ctrl #(
    parameter int COEFF_W    = 16,
    parameter int N_TAPS     = 64,
    parameter int N_BANDS    = 8,
    parameter int CNT_W      = $clog2(N_TAPS),
    parameter int BAND_W     = (N_BANDS > 1) ? $clog2(N_BANDS) : 1,
    parameter int SWAP_ALIGN = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_enable,
    input  logic [CNT_W-1:0]           current_count,
    input  logic                       frame_start,
    input  logic                       coeffs_en,
    input  logic [BAND_W-1:0]          write_band,
    input  logic [CNT_W-1:0]           write_address,
    input  logic [COEFF_W-1:0]         coeffs_in,
    input  logic                       write_enable,
    output logic                       swap_pending,
    output logic                       swap_done,
    output logic                       addr_err,
`ifdef COEFFS_READBACK_EN
    input  logic                       rd_en,
    input  logic [BAND_W-1:0]          rd_band,
    input  logic [CNT_W-1:0]           rd_address,
    input  logic                       rd_sel,
    output logic [COEFF_W-1:0]         rd_data,
    output logic                       rd_valid,
`endif
    output logic [N_BANDS*COEFF_W-1:0] product_mux
);

    // state | meaning
    // IDLE  | no swap requested; active bank stable
    // ARMED | swap requested, waiting for the copy edge (frame_start or next enabled cycle)
    typedef enum logic {IDLE, ARMED} state_t;

    state_t state, state_nxt;
    logic   copy_fire;
    logic   wr_req;
    logic   wr_in_range;
    logic   tap_ok;

    logic [COEFF_W-1:0] staging [N_BANDS][N_TAPS];
    logic [COEFF_W-1:0] active  [N_BANDS][N_TAPS];

    assign wr_req      = clk_enable && write_enable;
    assign wr_in_range = (int'(write_band) < N_BANDS) && (int'(write_address) < N_TAPS);
    assign tap_ok      = int'(current_count) < N_TAPS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request arriving on the copy edge keeps the FSM armed for one more swap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clk_enable && coeffs_en) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (copy_fire && !coeffs_en) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        swap_pending = (state == ARMED);
        copy_fire    = (state == ARMED) && clk_enable && (frame_start || (SWAP_ALIGN == 0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_done <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            swap_done <= copy_fire;
            if (wr_req && !wr_in_range) begin
                addr_err <= 1'b1;
            end
        end
    end

    // Copy reads staging before the same-edge write lands, so a coincident write waits for the next swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staging <= '{default: '0};
            active  <= '{default: '0};
        end else begin
            if (copy_fire) begin
                active <= staging;
            end
            if (wr_req && wr_in_range) begin
                staging[write_band][write_address] <= coeffs_in;
            end
        end
    end

    always_comb begin
        product_mux = '0;
        if (tap_ok) begin
            for (int b = 0; b < N_BANDS; b++) begin
                product_mux[b*COEFF_W +: COEFF_W] = active[b][current_count];
            end
        end
    end

`ifdef COEFFS_READBACK_EN
    logic rd_in_range;

    assign rd_in_range = (int'(rd_band) < N_BANDS) && (int'(rd_address) < N_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (!rd_in_range) begin
                    rd_data <= '0;
                end else if (rd_sel) begin
                    rd_data <= active[rd_band][rd_address];
                end else begin
                    rd_data <= staging[rd_band][rd_address];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_coeffs_bank_ctrl.sv
// Scoreboard bench for coeffs_bank_ctrl: two instances (frame-aligned 8x64, immediate 6x48)
// share one stimulus stream and are checked against a bank-level reference model.
module tb_coeffs_bank_ctrl;
    localparam int CW   = 16;
    localparam int NT_A = 64;
    localparam int NB_A = 8;
    localparam int NT_B = 48;
    localparam int NB_B = 6;
    typedef logic [NB_A*NT_A*CW-1:0] flat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_enable = 1'b0;
    logic        frame_start = 1'b0;
    logic        coeffs_en = 1'b0;
    logic        write_enable = 1'b0;
    logic [5:0]  current_count = '0;
    logic [5:0]  write_address = '0;
    logic [2:0]  write_band = '0;
    logic [15:0] coeffs_in = '0;

    logic pend_a, done_a, err_a, pend_b, done_b, err_b;
    logic [NB_A*CW-1:0] pm_a;
    logic [NB_B*CW-1:0] pm_b;

`ifdef COEFFS_READBACK_EN
    logic        rd_en = 1'b0;
    logic [2:0]  rd_band = '0;
    logic [5:0]  rd_address = '0;
    logic        rd_sel = 1'b0;
    logic [15:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
`endif

    coeffs_bank_ctrl #(.COEFF_W(CW), .N_TAPS(NT_A), .N_BANDS(NB_A), .SWAP_ALIGN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .current_count(current_count),
        .frame_start(frame_start), .coeffs_en(coeffs_en), .write_band(write_band),
        .write_address(write_address), .coeffs_in(coeffs_in), .write_enable(write_enable),
        .swap_pending(pend_a), .swap_done(done_a), .addr_err(err_a),
`ifdef COEFFS_READBACK_EN
        .rd_en(rd_en), .rd_band(rd_band), .rd_address(rd_address), .rd_sel(rd_sel),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a),
`endif
        .product_mux(pm_a)
    );

    coeffs_bank_ctrl #(.COEFF_W(CW), .N_TAPS(NT_B), .N_BANDS(NB_B), .SWAP_ALIGN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .current_count(current_count),
        .frame_start(frame_start), .coeffs_en(coeffs_en), .write_band(write_band),
        .write_address(write_address), .coeffs_in(coeffs_in), .write_enable(write_enable),
        .swap_pending(pend_b), .swap_done(done_b), .addr_err(err_b),
`ifdef COEFFS_READBACK_EN
        .rd_en(rd_en), .rd_band(rd_band), .rd_address(rd_address), .rd_sel(rd_sel),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b),
`endif
        .product_mux(pm_b)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 mirrors dut_a's configuration, index 1 dut_b's.
    int nt [2] = '{NT_A, NT_B};
    int nb [2] = '{NB_A, NB_B};
    int al [2] = '{1, 0};
    logic [15:0] stg_m [2][NB_A][NT_A];
    logic [15:0] act_m [2][NB_A][NT_A];
    bit    pend_m [2];
    bit    err_m  [2];
    bit    done_m [2];
    flat_t sq0 [$];
    flat_t sq1 [$];

    int tests = 0;
    int fails = 0;

    function automatic flat_t flat(input int i);
        flat_t f = '0;
        for (int b = 0; b < NB_A; b++)
            for (int t = 0; t < NT_A; t++)
                f[(b*NT_A + t)*CW +: CW] = act_m[i][b][t];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < NB_A; b++)
                for (int t = 0; t < NT_A; t++) begin
                    stg_m[i][b][t] = '0;
                    act_m[i][b][t] = '0;
                end
            pend_m[i] = 0;
            err_m[i]  = 0;
            done_m[i] = 0;
        end
        sq0.delete();
        sq1.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                done_m[i] = 0;
                if (clk_enable) begin
                    if (pend_m[i] && (frame_start || al[i] == 0)) begin
                        for (int b = 0; b < NB_A; b++)
                            for (int t = 0; t < NT_A; t++)
                                act_m[i][b][t] = stg_m[i][b][t];
                        done_m[i] = 1;
                        if (i == 0) sq0.push_back(flat(0));
                        else        sq1.push_back(flat(1));
                        pend_m[i] = coeffs_en;
                    end else if (coeffs_en) begin
                        pend_m[i] = 1;
                    end
                    if (write_enable) begin
                        if (int'(write_band) < nb[i] && int'(write_address) < nt[i])
                            stg_m[i][write_band][write_address] = coeffs_in;
                        else
                            err_m[i] = 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_tap(input int i, input int b);
        if (int'(current_count) < nt[i]) return act_m[i][b][current_count];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] snap_tap(input flat_t s, input int i, input int b);
        if (int'(current_count) < nt[i]) return s[(b*NT_A + int'(current_count))*CW +: CW];
        return 16'h0000;
    endfunction

    // Monitor: per-cycle status checks plus a scoreboard pop on every swap_done.
    always @(negedge clk) begin
        flat_t s;
        chk("pending_a", {15'b0, pend_a}, {15'b0, pend_m[0]});
        chk("pending_b", {15'b0, pend_b}, {15'b0, pend_m[1]});
        chk("done_a", {15'b0, done_a}, {15'b0, done_m[0]});
        chk("done_b", {15'b0, done_b}, {15'b0, done_m[1]});
        chk("addr_err_a", {15'b0, err_a}, {15'b0, err_m[0]});
        chk("addr_err_b", {15'b0, err_b}, {15'b0, err_m[1]});
        for (int b = 0; b < NB_A; b++) chk("pm_a", pm_a[b*CW +: CW], exp_tap(0, b));
        for (int b = 0; b < NB_B; b++) chk("pm_b", pm_b[b*CW +: CW], exp_tap(1, b));
        if (done_a === 1'b1) begin
            if (sq0.size() == 0) chk("sb_a_unexpected_done", 16'h1, 16'h0);
            else begin
                s = sq0.pop_front();
                for (int b = 0; b < NB_A; b++) chk("sb_a_swap", pm_a[b*CW +: CW], snap_tap(s, 0, b));
            end
        end
        if (done_b === 1'b1) begin
            if (sq1.size() == 0) chk("sb_b_unexpected_done", 16'h1, 16'h0);
            else begin
                s = sq1.pop_front();
                for (int b = 0; b < NB_B; b++) chk("sb_b_swap", pm_b[b*CW +: CW], snap_tap(s, 1, b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        frame_start  = 1'b0;
        coeffs_en    = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic set_wr(input logic [2:0] b, input logic [5:0] a, input logic [15:0] d);
        write_band    = b;
        write_address = a;
        coeffs_in     = d;
        write_enable  = 1'b1;
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        clk_enable = 1'b1;
        step();

        // band 2 tap 5, aligned swap waits for frame_start
        current_count = 6'd5;
        set_wr(3'd2, 6'd5, 16'h7FFF); step();
        coeffs_en = 1'b1; step();
        repeat (3) step();
        chk("pm_a_before_frame", pm_a[2*CW +: CW], 16'h0000);
        frame_start = 1'b1; step();
        step();
        chk("pm_a_band2_after_swap", pm_a[2*CW +: CW], 16'h7FFF);

        // write coincident with the copy edge
        current_count = 6'd0;
        set_wr(3'd0, 6'd0, 16'h0001); step();
        coeffs_en = 1'b1; step();
        frame_start = 1'b1; set_wr(3'd0, 6'd0, 16'h1234); step();
        step();
        chk("pm_a_coincident_old", pm_a[0 +: CW], 16'h0001);
        coeffs_en = 1'b1; step();
        frame_start = 1'b1; step();
        step();
        chk("pm_a_coincident_new", pm_a[0 +: CW], 16'h1234);

        // repeated requests while armed, then a request on the copy edge
        coeffs_en = 1'b1; step();
        step();
        coeffs_en = 1'b1; step();
        coeffs_en = 1'b1; step();
        frame_start = 1'b1; step();
        step();
        coeffs_en = 1'b1; step();
        step();
        frame_start = 1'b1; coeffs_en = 1'b1; step();
        repeat (3) step();
        frame_start = 1'b1; step();
        step();

        // clk_enable low freezes the FSM and drops writes
        coeffs_en = 1'b1; step();
        clk_enable = 1'b0;
        frame_start = 1'b1; set_wr(3'd1, 6'd1, 16'h5555); step();
        step();
        clk_enable = 1'b1; step();
        frame_start = 1'b1; step();
        step();

        // out-of-range writes for the 6x48 instance
        set_wr(3'd7, 6'd3, 16'hBEEF); step();
        set_wr(3'd2, 6'd63, 16'hCAFE); step();
        step();

        // async reset while armed with a non-zero active bank
        current_count = 6'd5;
        set_wr(3'd3, 6'd5, 16'hAAAA); step();
        coeffs_en = 1'b1; step();
        frame_start = 1'b1; step();
        set_wr(3'd3, 6'd5, 16'h5555); step();
        coeffs_en = 1'b1; step();
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_pm_a", pm_a[3*CW +: CW], 16'h0000);
        chk("async_rst_pend_a", {15'b0, pend_a}, 16'h0000);
        chk("async_rst_err_b", {15'b0, err_b}, 16'h0000);
        step();
        rst_n = 1'b1;
        frame_start = 1'b1; step();
        step();

        // randomized traffic
        repeat (2500) begin
            rst_n         = ($urandom_range(0, 399) != 0);
            clk_enable    = ($urandom_range(0, 99) < 85);
            current_count = 6'($urandom);
            write_enable  = ($urandom_range(0, 1) == 1);
            write_band    = 3'($urandom);
            write_address = 6'($urandom);
            coeffs_in     = 16'($urandom);
            coeffs_en     = ($urandom_range(0, 99) < 10);
            frame_start   = ($urandom_range(0, 99) < 12);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        clk_enable = 1'b1;
        frame_start = 1'b1;
        step();
        repeat (3) step();

        chk("sb_a_drained", 16'(sq0.size()), 16'h0000);
        chk("sb_b_drained", 16'(sq1.size()), 16'h0000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
